// File: rtl/cf_math_pkg.sv
// Small math helpers shared across the common cells.
package cf_math_pkg;

  // Bits needed to index num_idx items; never less than one.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/dummy_pkg.sv
// Shared types for the lzc decoder: buffer states, beat counter width, entry layout.
package dummy_pkg;
  import cf_math_pkg::*;

  localparam int unsigned DUMMY_BEAT_CNT_W = 16;
  localparam int unsigned DUMMY_DEC_W      = 8;
  localparam int unsigned DUMMY_DEC_CNT_W  = idx_width(DUMMY_DEC_W);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } dummy_buf_state_e;

  // Default-width entry; decoders of other widths declare the same layout locally.
  typedef struct packed {
    logic [DUMMY_DEC_W-1:0]     data;
    logic [DUMMY_DEC_CNT_W-1:0] cnt;
    logic                       empty;
  } dummy_dec_entry_t;

endpackage

// File: rtl/dummy_skid_buffer.sv
// Two-entry FIFO skid buffer with valid/ready on both sides.
// Latency: entry accepted on edge N is presented after edge N.
// Backpressure: in_rdy is registered, low only when both entries are held.
module dummy_skid_buffer
  import dummy_pkg::*;
#(
  parameter type entry_t = dummy_dec_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   in_vld,
  output logic   in_rdy,
  input  entry_t in_dat,
  output logic   out_vld,
  input  logic   out_rdy,
  output entry_t out_dat
);

  dummy_buf_state_e state_q, state_d;
  entry_t           head_q, tail_q;
  logic             push, pop;

  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_vld = (state_q != EMPTY);
  assign out_dat = head_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // head is always the oldest entry; tail only holds the second one while FULL
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      in_rdy  <= 1'b1;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      in_rdy  <= (state_d != FULL);
      if (state_q == FULL) begin
        if (pop) head_q <= tail_q;
      end else if (push && ((state_q == EMPTY) || pop)) begin
        head_q <= in_dat;
      end else if (push) begin
        tail_q <= in_dat;
      end
    end
  end

endmodule

// File: rtl/dummy_lzc_decoder.sv
// Inverts lzc {cnt, empty} pairs back to one-hot words; DUMMY_DECODER_SELFCHECK_EN adds an lzc re-encode check.
// Latency: one cycle from accept to data_o/valid_o, one beat per cycle sustained.
// Backpressure: two-entry skid buffer; ready_o is registered and drops only when both entries are held.
module dummy_lzc_decoder
  import dummy_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [CNT_W-1:0]            cnt_i,
  input  logic                        empty_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [WIDTH-1:0]            data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        err_o,
  output logic [DUMMY_BEAT_CNT_W-1:0] beats_o,
  output logic                        mismatch_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
`ifdef DUMMY_DECODER_SELFCHECK_EN
    logic [CNT_W-1:0] cnt;
    logic             empty;
`endif
  } entry_t;

  entry_t                      in_entry, out_entry;
  logic [31:0]                 cnt_ext;
  logic                        oor, accept, err_q;
  logic [DUMMY_BEAT_CNT_W-1:0] beats_q;

  assign cnt_ext = 32'(cnt_i);
  assign oor     = !empty_i && (cnt_ext >= WIDTH);
  assign accept  = valid_i && ready_o;

  // An out-of-range count matches no bit position, so it decodes to zero naturally
  always_comb begin
    in_entry = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!empty_i && (cnt_ext == ((MODE == 0) ? i : (WIDTH - 1 - i)))) in_entry.data[i] = 1'b1;
    end
`ifdef DUMMY_DECODER_SELFCHECK_EN
    in_entry.cnt   = cnt_i;
    in_entry.empty = empty_i;
`endif
  end

  dummy_skid_buffer #(
    .entry_t (entry_t)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_vld  (valid_i),
    .in_rdy  (ready_o),
    .in_dat  (in_entry),
    .out_vld (valid_o),
    .out_rdy (ready_i),
    .out_dat (out_entry)
  );

  assign data_o = out_entry.data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (beats_q != '1) beats_q <= beats_q + DUMMY_BEAT_CNT_W'(1);
      if (oor)           err_q   <= 1'b1;
    end
  end

  assign beats_o = beats_q;
  assign err_o   = err_q;

`ifdef DUMMY_DECODER_SELFCHECK_EN
  logic [CNT_W-1:0] re_cnt;
  logic             re_empty, stored_oor, mismatch_q;

  lzc #(
    .WIDTH (WIDTH),
    .MODE  (MODE != 0)
  ) u_lzc (
    .in_i    (out_entry.data),
    .cnt_o   (re_cnt),
    .empty_o (re_empty)
  );

  // The count is meaningless for empty beats, and out-of-range beats were already flagged
  assign stored_oor = !out_entry.empty && (32'(out_entry.cnt) >= WIDTH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= valid_o && ready_i && !stored_oor &&
                    ((re_empty != out_entry.empty) || (!out_entry.empty && (re_cnt != out_entry.cnt)));
    end
  end

  assign mismatch_o = mismatch_q;
`else
  assign mismatch_o = 1'b0;
`endif

endmodule
